// File: rtl/hog_image_loader_pkg.sv
// Shared definitions for the HOG image loader: bank indices, FSM states,
// default frame limits shared with the scaler, and the dimension check.
package hog_image_loader_pkg;

    localparam int HOG_IMGX = 136;
    localparam int HOG_IMGY = 136;

    // Bank index is {row parity, column parity}
    localparam logic [1:0] BANK_00 = 2'd0;
    localparam logic [1:0] BANK_01 = 2'd1;
    localparam logic [1:0] BANK_10 = 2'd2;
    localparam logic [1:0] BANK_11 = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } load_state_t;

    // A frame is legal when the width is even and both sides lie in 2..max
    function automatic logic dims_legal(input logic [15:0] w,
                                        input logic [15:0] h,
                                        input logic [15:0] max_w,
                                        input logic [15:0] max_h);
        return (w[0] == 1'b0) && (w >= 16'd2) && (w <= max_w) &&
               (h >= 16'd2) && (h <= max_h);
    endfunction

endpackage

// File: rtl/hog_image_loader_if.sv
// Pixel stream bus into the loader: data, valid, last-of-row and ready.
interface hog_image_loader_if #(
    parameter int P_WIDTH = 8
);
    logic [P_WIDTH-1:0] tdata;
    logic               tvalid;
    logic               tlast;
    logic               tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/hog_image_loader_bank_addr_gen.sv
// Column/row counters and 2x2-interleaved bank address generation.
// The row base advances by w/2 after every odd row, so no multiplier is needed.
module hog_bank_addr_gen
    import hog_image_loader_pkg::*;
#(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              advance,
    input  logic [15:0]       w,
    input  logic [15:0]       h,
    output logic [1:0]        bank,
    output logic [RAM_AW-1:0] addr,
    output logic              col_last,
    output logic              frame_last
);

    logic [15:0]       x;
    logic [15:0]       y;
    logic [RAM_AW-1:0] row_base;
    logic [RAM_AW-1:0] half_w;

    assign half_w     = RAM_AW'(w[15:1]);
    assign col_last   = (x == w - 16'd1);
    assign frame_last = col_last && (y == h - 16'd1);
    assign addr       = row_base + RAM_AW'(x[15:1]);

    // Bank select from the parities of the current row and column
    always_comb begin
        bank = BANK_00;
        case ({y[0], x[0]})
            2'b00:   bank = BANK_00;
            2'b01:   bank = BANK_01;
            2'b10:   bank = BANK_10;
            default: bank = BANK_11;
        endcase
    end

    // Counters step on each accepted pixel; row base moves once per row pair
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (clear) begin
            x        <= '0;
            y        <= '0;
            row_base <= '0;
        end else if (advance) begin
            if (col_last) begin
                x <= '0;
                y <= y + 16'd1;
                if (y[0]) begin
                    row_base <= row_base + half_w;
                end
            end else begin
                x <= x + 16'd1;
            end
        end
    end

endmodule

// File: rtl/hog_image_loader.sv
// Loads a raster pixel stream into four 2x2-interleaved source banks so the
// scaler can fetch all four bilinear neighbours in a single cycle.
module hog_image_loader
    import hog_image_loader_pkg::*;
#(
    parameter int RAM_AW  = 17,
    parameter int P_WIDTH = 8,
    parameter int IMGX    = HOG_IMGX,
    parameter int IMGY    = HOG_IMGY,
    parameter int DELAY   = 1
) (
    input  logic               aclk,
    input  logic               arest_n,
    input  logic               start,
    input  logic [15:0]        img_w,
    input  logic [15:0]        img_h,
    hog_image_loader_if.slave  s_axis,
    output logic               initial_ena_0,
    output logic               initial_ena_1,
    output logic               initial_ena_2,
    output logic               initial_ena_3,
    output logic               initial_wea_0,
    output logic               initial_wea_1,
    output logic               initial_wea_2,
    output logic               initial_wea_3,
    output logic [RAM_AW-1:0]  initial_addra_0,
    output logic [RAM_AW-1:0]  initial_addra_1,
    output logic [RAM_AW-1:0]  initial_addra_2,
    output logic [RAM_AW-1:0]  initial_addra_3,
    output logic [P_WIDTH-1:0] initial_dina_0,
    output logic [P_WIDTH-1:0] initial_dina_1,
    output logic [P_WIDTH-1:0] initial_dina_2,
    output logic [P_WIDTH-1:0] initial_dina_3,
    output logic [31:0]        row_signal,
    output logic               busy,
    output logic               load_done,
    output logic               cfg_err,
    output logic               tlast_err
);

    // Largest bank address (odd heights round up) must fit the bank width.
    // DELAY is kept for parameter compatibility with the scaler; registered
    // outputs here carry no assignment delay.
    localparam longint MAX_ADDR = longint'((IMGY + 1) / 2) * longint'(IMGX / 2) - 1;

    if (MAX_ADDR >= (longint'(1) << RAM_AW)) begin : g_addr_range_check
        $error("hog_image_loader: RAM_AW too small for IMGX x IMGY");
    end
    if (DELAY < 0) begin : g_delay_check
        $error("hog_image_loader: DELAY must be non-negative");
    end

    load_state_t        state;
    load_state_t        next_state;
    logic [15:0]        w_q;
    logic [15:0]        h_q;
    logic               legal;
    logic               start_ok;
    logic               hs;
    logic [1:0]         bank;
    logic [RAM_AW-1:0]  addr;
    logic               col_last;
    logic               frame_last;
    logic               ena_q  [4];
    logic [RAM_AW-1:0]  addr_q [4];
    logic [P_WIDTH-1:0] din_q  [4];

    assign legal         = dims_legal(img_w, img_h, 16'(IMGX), 16'(IMGY));
    assign start_ok      = (state == ST_IDLE) && start && legal;
    assign s_axis.tready = (state == ST_LOAD);
    assign hs            = s_axis.tvalid && (state == ST_LOAD);

    hog_bank_addr_gen #(
        .RAM_AW (RAM_AW)
    ) u_addr_gen (
        .clk        (aclk),
        .rst_n      (arest_n),
        .clear      (start_ok),
        .advance    (hs),
        .w          (w_q),
        .h          (h_q),
        .bank       (bank),
        .addr       (addr),
        .col_last   (col_last),
        .frame_last (frame_last)
    );

    // State register
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state: start only counts in IDLE, the frame's last pixel ends LOAD
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start_ok) next_state = ST_LOAD;
            ST_LOAD: if (hs && frame_last) next_state = ST_DONE;
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Frame configuration, status flags and the completed-row counter
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            w_q        <= '0;
            h_q        <= '0;
            busy       <= 1'b0;
            load_done  <= 1'b0;
            cfg_err    <= 1'b0;
            tlast_err  <= 1'b0;
            row_signal <= '0;
        end else begin
            busy      <= (next_state == ST_LOAD);
            load_done <= (state == ST_DONE);
            cfg_err   <= (state == ST_IDLE) && start && !legal;
            if (start_ok) begin
                w_q        <= img_w;
                h_q        <= img_h;
                row_signal <= '0;
                tlast_err  <= 1'b0;
            end else if (hs) begin
                if (col_last) begin
                    row_signal <= row_signal + 32'd1;
                end
                if (s_axis.tlast != col_last) begin
                    tlast_err <= 1'b1;
                end
            end
        end
    end

    // Registered bank writes: only the selected bank fires, others idle;
    // address and data of an idle bank hold their last value
    always_ff @(posedge aclk or negedge arest_n) begin
        if (!arest_n) begin
            for (int b = 0; b < 4; b++) begin
                ena_q[b]  <= 1'b0;
                addr_q[b] <= '0;
                din_q[b]  <= '0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                ena_q[b] <= hs && (bank == 2'(b));
                if (hs && (bank == 2'(b))) begin
                    addr_q[b] <= addr;
                    din_q[b]  <= s_axis.tdata;
                end
            end
        end
    end

    assign initial_ena_0   = ena_q[0];
    assign initial_ena_1   = ena_q[1];
    assign initial_ena_2   = ena_q[2];
    assign initial_ena_3   = ena_q[3];
    assign initial_wea_0   = ena_q[0];
    assign initial_wea_1   = ena_q[1];
    assign initial_wea_2   = ena_q[2];
    assign initial_wea_3   = ena_q[3];
    assign initial_addra_0 = addr_q[0];
    assign initial_addra_1 = addr_q[1];
    assign initial_addra_2 = addr_q[2];
    assign initial_addra_3 = addr_q[3];
    assign initial_dina_0  = din_q[0];
    assign initial_dina_1  = din_q[1];
    assign initial_dina_2  = din_q[2];
    assign initial_dina_3  = din_q[3];

endmodule
